// File: rtl/aud_rmm_arb_pkg.sv
// Shared types and helpers for the AUD remote-memory-access arbiter.
package aud_rmm_arb_pkg;

    // Sequencer states: one full engine access per grant, plus watchdog recovery.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_RESP       = 3'd4,
        ST_RECOVER    = 3'd5
    } state_t;

    // Access size codes: 1 << size nibbles.
    typedef enum logic [1:0] {
        SZ_1N = 2'd0,
        SZ_2N = 2'd1,
        SZ_4N = 2'd2,
        SZ_8N = 2'd3
    } size_t;

    // Keep only the nibbles the access actually returned.
    function automatic logic [31:0] rd_mask(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] m;
        case (size)
            SZ_1N:   m = 32'h0000_000F;
            SZ_2N:   m = 32'h0000_00FF;
            SZ_4N:   m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return d & m;
    endfunction

endpackage

// File: rtl/aud_rmm_arb_if.sv
// Requester-side bus of the AUD engine arbiter; all requesters packed side by side.
interface aud_rmm_arb_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       we;
    logic [N_REQ-1:0][31:0] addr;
    logic [N_REQ-1:0][31:0] wdata;
    logic [N_REQ-1:0][1:0]  size;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic                   err;
    logic [31:0]            rdata;

    // Requesters drive requests and observe grant/completion.
    modport master (
        output req, we, addr, wdata, size,
        input  gnt, ack, err, rdata
    );

    // The arbiter consumes requests and returns grant/completion.
    modport slave (
        input  req, we, addr, wdata, size,
        output gnt, ack, err, rdata
    );
endinterface

// File: rtl/aud_rr_pick.sv
// Round-robin picker: first set request strictly after ptr, wrapping.
module aud_rr_pick #(
    parameter int N_REQ = 2,
    parameter int IW    = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             any
);
    int            c;
    logic [IW-1:0] ci;
    logic          found;

    // Scan from ptr+1 around to ptr itself so ptr gets lowest priority.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        c     = 0;
        ci    = '0;
        found = 1'b0;
        any   = |req;
        for (int k = 1; k <= N_REQ; k++) begin
            c  = (int'(ptr) + k) % N_REQ;
            ci = IW'(c);
            if (!found && req[ci]) begin
                found   = 1'b1;
                gnt[ci] = 1'b1;
                idx     = ci;
            end
        end
    end
endmodule

// File: rtl/aud_rmm_arb.sv
// Round-robin arbiter and sequencer in front of the single AUD RMM engine.
// Runs one strobe/busy/done access per grant and aborts a stuck engine.
module aud_rmm_arb
    import aud_rmm_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 4096,
    parameter int RST_CYC = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    aud_rmm_arb_if.slave  rq,
    output logic          timeout_o,
    output logic [31:0]   rmm_addr_o,
    output logic [31:0]   rmm_data_o,
    output logic [1:0]    rmm_size_o,
    output logic          rmm_we_o,
    output logic          rmm_re_o,
    input  logic [31:0]   rmm_data_i,
    input  logic          rmm_err_i,
    input  logic          rmm_idle_i,
    output logic          rmm_rst_o
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    state_t           state;
    logic [IW-1:0]    ptr;
    logic             we_q;
    logic [TW-1:0]    wd_cnt;
    logic [RW-1:0]    rc_cnt;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] ack_q;
    logic             err_q;
    logic [31:0]      rdata_q;

    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic             wd_hit;

    aud_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req (rq.req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign wd_hit   = (wd_cnt == TW'(TIMEOUT - 1));
    assign rq.gnt   = gnt_q;
    assign rq.ack   = ack_q;
    assign rq.err   = err_q;
    assign rq.rdata = rdata_q;

    // Sequencer FSM with registered outputs; strobes and response are one-cycle pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            ptr        <= IW'(N_REQ - 1);
            we_q       <= 1'b0;
            wd_cnt     <= '0;
            rc_cnt     <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            timeout_o  <= 1'b0;
            rmm_addr_o <= '0;
            rmm_data_o <= '0;
            rmm_size_o <= '0;
            rmm_we_o   <= 1'b0;
            rmm_re_o   <= 1'b0;
            rmm_rst_o  <= 1'b0;
        end else begin
            rmm_we_o  <= 1'b0;
            rmm_re_o  <= 1'b0;
            ack_q     <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            timeout_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // An engine still busy (e.g. after an abort) blocks new grants.
                    if (pick_any && rmm_idle_i) begin
                        gnt_q      <= pick_gnt;
                        ptr        <= pick_idx;
                        we_q       <= rq.we[pick_idx];
                        rmm_addr_o <= rq.addr[pick_idx];
                        rmm_data_o <= rq.wdata[pick_idx];
                        rmm_size_o <= rq.size[pick_idx];
                        rmm_we_o   <= rq.we[pick_idx];
                        rmm_re_o   <= ~rq.we[pick_idx];
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wd_cnt <= '0;
                    state  <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    // Abort takes priority here so the counter never wraps into WAIT_DONE.
                    if (wd_hit) begin
                        timeout_o <= 1'b1;
                        rmm_rst_o <= 1'b1;
                        rc_cnt    <= '0;
                        state     <= ST_RECOVER;
                    end else if (!rmm_idle_i) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    // Completion wins over a same-cycle watchdog hit.
                    if (rmm_idle_i) begin
                        ack_q   <= gnt_q;
                        err_q   <= rmm_err_i;
                        rdata_q <= we_q ? 32'h0 : rd_mask(rmm_size_o, rmm_data_i);
                        state   <= ST_RESP;
                    end else if (wd_hit) begin
                        timeout_o <= 1'b1;
                        rmm_rst_o <= 1'b1;
                        rc_cnt    <= '0;
                        state     <= ST_RECOVER;
                    end
                end
                ST_RESP: begin
                    gnt_q      <= '0;
                    rmm_addr_o <= '0;
                    rmm_data_o <= '0;
                    rmm_size_o <= '0;
                    state      <= ST_IDLE;
                end
                ST_RECOVER: begin
                    if (rc_cnt == RW'(RST_CYC - 1)) begin
                        rmm_rst_o <= 1'b0;
                        ack_q     <= gnt_q;
                        err_q     <= 1'b1;
                        rdata_q   <= '0;
                        state     <= ST_RESP;
                    end else begin
                        rc_cnt <= rc_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
